// File: rtl/rv_exu_if.sv
// Bundle between decode, the execute stage and its two result consumers.
// Valid/ready: a transfer happens on a rising clk edge where valid and ready are both 1.
// The sender holds its payload stable while valid is high and ready is low.
interface rv_exu_if;
    logic        alu_op_valid;
    logic [3:0]  alu_op;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic        alu_reg_mem_n;
    logic [4:0]  alu_addr;
    logic        alu_rdy;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic        mem_res_valid;
    logic [31:0] mem_res_data;
    logic        mem_res_rdy;
    logic        illegal_op;
    logic [31:0] op_count;

    modport master (
        output alu_op_valid, alu_op, alu_in1, alu_in2, alu_reg_mem_n, alu_addr, mem_res_rdy,
        input  alu_rdy, rf_wr_en, rf_wr_addr, rf_wr_data, mem_res_valid, mem_res_data,
        input  illegal_op, op_count
    );

    modport slave (
        input  alu_op_valid, alu_op, alu_in1, alu_in2, alu_reg_mem_n, alu_addr, mem_res_rdy,
        output alu_rdy, rf_wr_en, rf_wr_addr, rf_wr_data, mem_res_valid, mem_res_data,
        output illegal_op, op_count
    );
endinterface

// File: rtl/rv_exu.sv
// Execute stage: single-cycle ALU ops, iterative shifts, and a held result
// toward the load/store path for memory-destined ops.
module rv_exu #(
    parameter int SHIFT_STEP = 1,
    parameter int XLEN       = 32
) (
    input  logic       clk,
    input  logic       reset,
    rv_exu_if.slave    ex,
    output logic [1:0] state_dbg
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [5:0] STEP = 6'(SHIFT_STEP);

    state_t          state;
    logic [XLEN-1:0] alu_res;
    logic            op_illegal;
    logic            op_is_shift;
    logic [4:0]      amt;

    logic [XLEN-1:0] sh_val;
    logic [XLEN-1:0] sh_next;
    logic [5:0]      sh_cnt;
    logic [5:0]      step;
    logic [1:0]      sh_kind;
    logic [4:0]      sh_dest;
    logic            sh_to_rf;

    logic            dlv_go;
    logic [XLEN-1:0] dlv_val;
    logic [4:0]      dlv_dest;
    logic            dlv_to_rf;

    assign amt         = ex.alu_in2[4:0];
    assign op_is_shift = (ex.alu_op == 4'h5) || (ex.alu_op == 4'h6) || (ex.alu_op == 4'h7);
    assign ex.alu_rdy  = (state == IDLE);
    assign state_dbg   = state;

    always_comb begin
        alu_res    = '0;
        op_illegal = 1'b0;
        case (ex.alu_op)
            4'h0: alu_res = ex.alu_in1 + ex.alu_in2;
            4'h1: alu_res = ex.alu_in1 - ex.alu_in2;
            4'h2: alu_res = ex.alu_in1 | ex.alu_in2;
            4'h3: alu_res = ex.alu_in1 & ex.alu_in2;
            4'h4: alu_res = ex.alu_in1 ^ ex.alu_in2;
            4'h5: alu_res = ex.alu_in1 << amt;
            4'h6: alu_res = ex.alu_in1 >> amt;
            4'h7: alu_res = $unsigned($signed(ex.alu_in1) >>> amt);
            4'h8: alu_res = {{(XLEN-1){1'b0}}, ($signed(ex.alu_in1) < $signed(ex.alu_in2))};
            4'h9: alu_res = {{(XLEN-1){1'b0}}, (ex.alu_in1 < ex.alu_in2)};
            default: op_illegal = 1'b1;
        endcase
    end

    // Last step of a shift may be shorter than SHIFT_STEP.
    always_comb begin
        step    = (sh_cnt < STEP) ? sh_cnt : STEP;
        sh_next = sh_val;
        case (sh_kind)
            2'b01:   sh_next = sh_val << step;
            2'b10:   sh_next = sh_val >> step;
            default: sh_next = $unsigned($signed(sh_val) >>> step);
        endcase
    end

    // Delivery source: straight from the ALU in IDLE, or the final shift step.
    always_comb begin
        dlv_go    = 1'b0;
        dlv_val   = alu_res;
        dlv_dest  = ex.alu_addr;
        dlv_to_rf = ex.alu_reg_mem_n;
        if (state == IDLE) begin
            dlv_go = ex.alu_op_valid && !(op_is_shift && (amt != 5'd0));
        end else if (state == SHIFT) begin
            dlv_go    = (sh_cnt == step);
            dlv_val   = sh_next;
            dlv_dest  = sh_dest;
            dlv_to_rf = sh_to_rf;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            sh_val           <= '0;
            sh_cnt           <= '0;
            sh_kind          <= '0;
            sh_dest          <= '0;
            sh_to_rf         <= 1'b0;
            ex.rf_wr_en      <= 1'b0;
            ex.rf_wr_addr    <= '0;
            ex.rf_wr_data    <= '0;
            ex.mem_res_valid <= 1'b0;
            ex.mem_res_data  <= '0;
            ex.illegal_op    <= 1'b0;
            ex.op_count      <= '0;
        end else begin
            ex.rf_wr_en <= 1'b0;

            if (state == IDLE && ex.alu_op_valid) begin
                if (op_illegal) begin
                    ex.illegal_op <= 1'b1;
                end
                if (op_is_shift && (amt != 5'd0)) begin
                    state    <= SHIFT;
                    sh_val   <= ex.alu_in1;
                    sh_cnt   <= {1'b0, amt};
                    sh_kind  <= ex.alu_op[1:0];
                    sh_dest  <= ex.alu_addr;
                    sh_to_rf <= ex.alu_reg_mem_n;
                end
            end

            if (state == SHIFT) begin
                sh_val <= sh_next;
                sh_cnt <= sh_cnt - step;
            end

            if (dlv_go) begin
                if (dlv_to_rf) begin
                    // x0 writes are swallowed but still retire.
                    state       <= IDLE;
                    ex.op_count <= ex.op_count + 32'd1;
                    if (dlv_dest != 5'd0) begin
                        ex.rf_wr_en   <= 1'b1;
                        ex.rf_wr_addr <= dlv_dest;
                        ex.rf_wr_data <= dlv_val;
                    end
                end else begin
                    state            <= HOLD;
                    ex.mem_res_valid <= 1'b1;
                    ex.mem_res_data  <= dlv_val;
                end
            end

            if (state == HOLD && ex.mem_res_rdy) begin
                state            <= IDLE;
                ex.mem_res_valid <= 1'b0;
                ex.op_count      <= ex.op_count + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_rv_exu.sv
// Bench for rv_exu: a result-level model checked every cycle, an rf write queue,
// and directed vectors with literal expectations.
module tb_rv_exu;
    localparam int S1 = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] st1;
    logic [1:0] st8;

    always #5 clk = ~clk;

    rv_exu_if ex ();
    rv_exu_if ex8 ();

    rv_exu #(.SHIFT_STEP(1), .XLEN(32)) dut  (.clk(clk), .reset(reset), .ex(ex),  .state_dbg(st1));
    rv_exu #(.SHIFT_STEP(8), .XLEN(32)) dut8 (.clk(clk), .reset(reset), .ex(ex8), .state_dbg(st8));

    int n_checks = 0;
    int n_pass   = 0;
    bit run_chk  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- model ----------------
    int          m_busy   = 0;
    bit          m_hold   = 1'b0;
    bit          m_rf_en  = 1'b0;
    logic [4:0]  m_rf_addr  = '0;
    logic [31:0] m_rf_data  = '0;
    logic [31:0] m_mem_data = '0;
    logic [31:0] m_count  = '0;
    bit          m_ill    = 1'b0;
    logic [31:0] p_res;
    logic [4:0]  p_dest;
    bit          p_rf;
    logic [31:0] m_r;
    bit          m_i;
    logic [36:0] exp_q[$];

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, output bit ill);
        int s;
        s   = int'(b[4:0]);
        ill = 1'b0;
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a | b;
            4'h3: return a & b;
            4'h4: return a ^ b;
            4'h5: return a << s;
            4'h6: return a >> s;
            4'h7: return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
            4'h8: return (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, (a < b)};
            4'h9: return {31'b0, (a < b)};
            default: begin ill = 1'b1; return 32'h0; end
        endcase
    endfunction

    task automatic m_deliver(input logic [31:0] r, input logic [4:0] d, input bit to_rf);
        if (to_rf) begin
            m_count = m_count + 32'd1;
            if (d != 5'd0) begin
                m_rf_en   = 1'b1;
                m_rf_addr = d;
                m_rf_data = r;
                exp_q.push_back({d, r});
            end
        end else begin
            m_hold     = 1'b1;
            m_mem_data = r;
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 0; m_hold = 1'b0; m_rf_en = 1'b0; m_rf_addr = '0; m_rf_data = '0;
            m_mem_data = '0; m_count = '0; m_ill = 1'b0;
            exp_q.delete();
        end else begin
            m_rf_en = 1'b0;
            if (m_hold) begin
                if (ex.mem_res_rdy) begin
                    m_hold  = 1'b0;
                    m_count = m_count + 32'd1;
                end
            end else if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) m_deliver(p_res, p_dest, p_rf);
            end else if (ex.alu_op_valid) begin
                m_r = ref_alu(ex.alu_op, ex.alu_in1, ex.alu_in2, m_i);
                if (m_i) m_ill = 1'b1;
                if ((ex.alu_op inside {4'h5, 4'h6, 4'h7}) && ex.alu_in2[4:0] != 5'd0) begin
                    m_busy = (int'(ex.alu_in2[4:0]) + S1 - 1) / S1;
                    p_res  = m_r;
                    p_dest = ex.alu_addr;
                    p_rf   = ex.alu_reg_mem_n;
                end else begin
                    m_deliver(m_r, ex.alu_addr, ex.alu_reg_mem_n);
                end
            end
        end
    end

    // ---------------- compare ----------------
    logic [36:0] got;
    always @(negedge clk) begin
        if (!reset && run_chk) begin
            chk("alu_rdy",       ex.alu_rdy,       (!m_hold && m_busy == 0));
            chk("rf_wr_en",      ex.rf_wr_en,      m_rf_en);
            chk("rf_wr_addr",    ex.rf_wr_addr,    m_rf_addr);
            chk("rf_wr_data",    ex.rf_wr_data,    m_rf_data);
            chk("mem_res_valid", ex.mem_res_valid, m_hold);
            if (m_hold) chk("mem_res_data", ex.mem_res_data, m_mem_data);
            chk("illegal_op",    ex.illegal_op,    m_ill);
            chk("op_count",      ex.op_count,      m_count);
            if (ex.rf_wr_en) begin
                if (exp_q.size() == 0) begin
                    chk("rf_q_unexpected", ex.rf_wr_en, 0);
                end else begin
                    got = {ex.rf_wr_addr, ex.rf_wr_data};
                    chk("rf_q_order", got, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic rm, input logic [4:0] d);
        int n;
        ex.alu_op = op; ex.alu_in1 = a; ex.alu_in2 = b; ex.alu_reg_mem_n = rm; ex.alu_addr = d;
        ex.alu_op_valid = 1'b1;
        n = 0;
        while (!ex.alu_rdy && n < 200) begin n++; @(negedge clk); end
        chk("send_rdy", ex.alu_rdy, 1);
        @(negedge clk);
        ex.alu_op_valid = 1'b0;
    endtask

    task automatic wait_rdy(output int low);
        low = 0;
        while (!ex.alu_rdy && low < 200) begin low++; @(negedge clk); end
    endtask

    int low;
    int n;

    initial begin
        reset = 1'b1;
        ex.alu_op_valid = 1'b0; ex.alu_op = '0; ex.alu_in1 = '0; ex.alu_in2 = '0;
        ex.alu_reg_mem_n = 1'b1; ex.alu_addr = '0; ex.mem_res_rdy = 1'b0;
        ex8.alu_op_valid = 1'b0; ex8.alu_op = '0; ex8.alu_in1 = '0; ex8.alu_in2 = '0;
        ex8.alu_reg_mem_n = 1'b1; ex8.alu_addr = '0; ex8.mem_res_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset alu_rdy",    ex.alu_rdy, 1);
        chk("reset rf_wr_en",   ex.rf_wr_en, 0);
        chk("reset mem_valid",  ex.mem_res_valid, 0);
        chk("reset illegal",    ex.illegal_op, 0);
        chk("reset op_count",   ex.op_count, 0);
        chk("reset rf_wr_data", ex.rf_wr_data, 0);
        chk("reset8 alu_rdy",   ex8.alu_rdy, 1);
        reset = 1'b0;
        run_chk = 1'b1;
        @(negedge clk);

        // back-to-back register ops
        send(4'h0, 32'd7, 32'd9, 1'b1, 5'd5);
        chk("add en", ex.rf_wr_en, 1);
        chk("add addr", ex.rf_wr_addr, 5);
        chk("add data", ex.rf_wr_data, 16);
        send(4'h1, 32'd3, 32'd5, 1'b1, 5'd6);
        chk("sub addr", ex.rf_wr_addr, 6);
        chk("sub data", ex.rf_wr_data, 32'hFFFF_FFFE);
        chk("t1 op_count", ex.op_count, 2);

        // iterative shifts
        send(4'h5, 32'd1, 32'd31, 1'b1, 5'd8);
        wait_rdy(low);
        chk("sll31 stall", low, 31);
        chk("sll31 data", ex.rf_wr_data, 32'h8000_0000);
        chk("sll31 en", ex.rf_wr_en, 1);
        send(4'h7, 32'h8000_0000, 32'd4, 1'b1, 5'd9);
        wait_rdy(low);
        chk("sra4 stall", low, 4);
        chk("sra4 data", ex.rf_wr_data, 32'hF800_0000);

        ex8.alu_op = 4'h5; ex8.alu_in1 = 32'd1; ex8.alu_in2 = 32'd31;
        ex8.alu_reg_mem_n = 1'b1; ex8.alu_addr = 5'd3; ex8.alu_op_valid = 1'b1;
        @(negedge clk);
        ex8.alu_op_valid = 1'b0;
        low = 0;
        while (!ex8.alu_rdy && low < 200) begin low++; @(negedge clk); end
        chk("step8 stall", low, 4);
        chk("step8 en", ex8.rf_wr_en, 1);
        chk("step8 addr", ex8.rf_wr_addr, 3);
        chk("step8 data", ex8.rf_wr_data, 32'h8000_0000);

        // memory destination with backpressure; next op held by upstream
        send(4'h3, 32'hF0F0, 32'h0FF0, 1'b0, 5'd10);
        ex.alu_op = 4'h0; ex.alu_in1 = 32'd1; ex.alu_in2 = 32'd2;
        ex.alu_reg_mem_n = 1'b1; ex.alu_addr = 5'd7; ex.alu_op_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("hold valid", ex.mem_res_valid, 1);
            chk("hold data", ex.mem_res_data, 32'h00F0);
            chk("hold rdy", ex.alu_rdy, 0);
            @(negedge clk);
        end
        ex.mem_res_rdy = 1'b1;
        @(negedge clk);
        ex.mem_res_rdy = 1'b0;
        chk("hs valid drop", ex.mem_res_valid, 0);
        chk("hs rdy", ex.alu_rdy, 1);
        @(negedge clk);
        ex.alu_op_valid = 1'b0;
        chk("held op en", ex.rf_wr_en, 1);
        chk("held op addr", ex.rf_wr_addr, 7);
        chk("held op data", ex.rf_wr_data, 3);
        chk("t3 op_count", ex.op_count, 6);

        // x0 and illegal op
        send(4'h0, 32'd1, 32'd1, 1'b1, 5'd0);
        chk("x0 en", ex.rf_wr_en, 0);
        chk("x0 count", ex.op_count, 7);
        chk("x0 held addr", ex.rf_wr_addr, 7);
        send(4'hC, 32'd5, 32'd6, 1'b1, 5'd9);
        chk("ill en", ex.rf_wr_en, 1);
        chk("ill data", ex.rf_wr_data, 0);
        chk("ill flag", ex.illegal_op, 1);
        send(4'h0, 32'd2, 32'd2, 1'b1, 5'd10);
        chk("ill sticky", ex.illegal_op, 1);
        chk("after ill data", ex.rf_wr_data, 4);

        // comparisons, wrap, misc ops
        send(4'h8, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd11);
        chk("slt", ex.rf_wr_data, 1);
        send(4'h9, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd12);
        chk("sltu", ex.rf_wr_data, 0);
        send(4'h0, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd13);
        chk("add wrap", ex.rf_wr_data, 0);
        chk("add wrap en", ex.rf_wr_en, 1);
        send(4'h2, 32'hA0, 32'h0A, 1'b1, 5'd14);
        chk("or", ex.rf_wr_data, 32'hAA);
        send(4'h4, 32'hFF, 32'h0F, 1'b1, 5'd15);
        chk("xor", ex.rf_wr_data, 32'hF0);
        send(4'h5, 32'h1234, 32'd32, 1'b1, 5'd16);
        chk("sll amt0 data", ex.rf_wr_data, 32'h1234);
        chk("sll amt0 en", ex.rf_wr_en, 1);
        send(4'h6, 32'hF0, 32'd4, 1'b0, 5'd0);
        ex.mem_res_rdy = 1'b1;
        n = 0;
        while (!ex.mem_res_valid && n < 50) begin n++; @(negedge clk); end
        chk("srl mem valid", ex.mem_res_valid, 1);
        chk("srl mem data", ex.mem_res_data, 32'h0F);
        @(negedge clk);
        ex.mem_res_rdy = 1'b0;
        chk("srl mem drop", ex.mem_res_valid, 0);
        send(4'h7, 32'h7000_0000, 32'd4, 1'b1, 5'd17);
        wait_rdy(low);
        chk("sra pos data", ex.rf_wr_data, 32'h0700_0000);
        chk("t6 op_count", ex.op_count, 17);

        // asynchronous reset in the middle of a shift
        ex.alu_op = 4'h5; ex.alu_in1 = 32'd1; ex.alu_in2 = 32'd20;
        ex.alu_reg_mem_n = 1'b1; ex.alu_addr = 5'd20; ex.alu_op_valid = 1'b1;
        @(negedge clk);
        ex.alu_op_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre-reset busy", ex.alu_rdy, 0);
        #2 reset = 1'b1;
        #1;
        chk("arst alu_rdy", ex.alu_rdy, 1);
        chk("arst rf_wr_en", ex.rf_wr_en, 0);
        chk("arst op_count", ex.op_count, 0);
        chk("arst illegal", ex.illegal_op, 0);
        chk("arst mem_valid", ex.mem_res_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("post-reset count", ex.op_count, 0);
        send(4'h0, 32'd2, 32'd3, 1'b1, 5'd21);
        chk("post-reset data", ex.rf_wr_data, 5);
        chk("post-reset op_count", ex.op_count, 1);

        @(negedge clk);
        chk("exp_q drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/rv_exu.md
Name: rv_exu

Overview:
- Execute stage directly downstream of the fetch/decode unit. It consumes the registered ALU operation bundle (op, two operands, destination, reg/mem select) under a valid/ready handshake and computes the result.
- Register-destined results go to the register file write port. Memory-destined results go through a backpressured result channel toward the load/store path.
- Shifts are iterative, so the block stalls decode via alu_rdy.

Parameters:
SHIFT_STEP, 1, bits shifted per cycle in iterative shifts; legal values 1,2,4,8,16,32.
XLEN, 32, datapath width; only 32 is supported.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
alu_op_valid  in  1  op bundle valid
alu_op  in  4  operation code
alu_in1  in  32  operand 1 (rs1 value)
alu_in2  in  32  operand 2 (rs2 value)
alu_reg_mem_n  in  1  1 = result to register file, 0 = result to memory channel
alu_addr  in  5  destination register index
alu_rdy  out  1  1 = block accepts a new op this cycle
rf_wr_en  out  1  register file write strobe (single-cycle pulse)
rf_wr_addr  out  5  write index
rf_wr_data  out  32  write data
mem_res_valid  out  1  memory-channel result valid
mem_res_data  out  32  memory-channel result (address/data)
mem_res_rdy  in  1  memory channel accepts result
illegal_op  out  1  sticky flag: an undefined alu_op was accepted
op_count  out  32  retired-op counter, wraps at 2^32

Behaviour:
- Reset is asynchronous, active-high, clock clk. State = IDLE. All outputs 0 except alu_rdy = 1 (combinational from IDLE). Reset mid-operation aborts the op: no rf write and no mem_res.
- Accept happens when alu_op_valid && alu_rdy at a rising edge. alu_op_valid while alu_rdy=0 is ignored; upstream holds the bundle.
- Op codes (unsigned 32-bit wraparound arithmetic, no overflow flag):
  - 0000 ADD, 0001 SUB, 0010 OR, 0011 AND, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA, with shift amount = alu_in2[4:0].
  - 1000 SLT (signed), 1001 SLTU, result 0 or 1.
  - 1010-1111 are illegal: result 0, illegal_op set and held until reset; the op is still completed and counted.
- States: IDLE, SHIFT, HOLD.
- IDLE, non-shift op or shift with amount 0:
  - Result is registered on the accept edge.
  - If alu_reg_mem_n=1, rf_wr_en=1 for exactly the next cycle (latency 1), and the state stays IDLE, so throughput is 1 op/cycle.
  - If alu_reg_mem_n=0, go to HOLD with mem_res_valid=1.
- IDLE, shift with amount>0:
  - Go to SHIFT; load the remaining count = amount.
  - Each cycle, shift by min(SHIFT_STEP, remaining).
  - When remaining reaches 0, deliver as above: rf pulse on the following cycle, or HOLD. Total latency = ceil(amount/SHIFT_STEP)+1 cycles.
  - SRA replicates bit 31 every step.
- SHIFT: alu_rdy=0.
- HOLD: alu_rdy=0. mem_res_valid and mem_res_data stay stable until mem_res_rdy=1; that edge returns to IDLE and mem_res_valid drops. mem_res_rdy outside HOLD is ignored.
- A write to x0 (alu_addr=0, reg dest) suppresses rf_wr_en, but the op is consumed and counted.
- op_count increments by 1 on the cycle the result is delivered: the rf pulse cycle, the x0-suppressed equivalent cycle, or the mem handshake edge.
- rf_wr_addr/rf_wr_data hold their last values when rf_wr_en=0.
- No forwarding. Decode-side hazards are the decode stage's responsibility.

Test Plan:
1. Back-to-back ADD x5=7+9 then SUB x6=3-5, alu_reg_mem_n=1 -> rf_wr_en on consecutive cycles: (5,16), then (6,32'hFFFF_FFFE); alu_rdy stays 1; op_count=2.
2. SLL alu_in1=1, alu_in2=31, SHIFT_STEP=1 -> alu_rdy low for 31 cycles, then rf_wr_data=32'h8000_0000. Repeat with SRA of 32'h8000_0000 by 4 -> 32'hF800_0000. Repeat with SHIFT_STEP=8 and amount 31 -> 4 shift cycles.
3. AND to memory (alu_reg_mem_n=0), 32'hF0F0 & 32'h0FF0, mem_res_rdy held low 5 cycles -> mem_res_valid=1 with data 32'h00F0 stable for 5 cycles, alu_rdy=0, a new alu_op_valid is ignored; mem_res_rdy=1 -> valid drops and the held op is accepted the next cycle.
4. ADD to x0 -> no rf_wr_en, op_count increments. alu_op=4'b1100 -> result 0 written, illegal_op=1 and stays set.
5. Assert reset asynchronously mid-SHIFT (after 3 cycles of a 20-bit shift) -> alu_rdy=1, no rf_wr_en, op_count=0, illegal_op=0 immediately.
6. SLT -1 vs 1 -> 1; SLTU 32'hFFFF_FFFF vs 1 -> 0; ADD 32'hFFFF_FFFF+1 -> 0 (wrap).
